// File: rtl/sha256_mem_responder.sv
// sha256_mem_responder: word RAM serving the SHA-256 engine memory port, with host
// load/readback, start/done sequencing and digest-window completion monitoring.
module sha256_mem_responder #(
    parameter int unsigned DEPTH         = 64,
    parameter logic [15:0] MSG_BASE      = 16'd0,
    parameter logic [15:0] OUT_BASE      = 16'd32,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_addr,
    input  logic        mem_we,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        eng_start,
    input  logic        eng_done,
    output logic [15:0] message_addr,
    output logic [15:0] output_addr,
    input  logic        host_we,
    input  logic        host_re,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    input  logic        host_start,
    output logic        host_rej,
    output logic        busy,
    output logic        result_valid,
    output logic        oob_err,
    output logic        timeout_err,
    output logic [3:0]  eng_wr_count
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [7:0]  TMR_LAST = 8'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, CHECK} state_t;

    state_t      state_q, state_d;
    logic [31:0] ram_q [DEPTH];
    logic [31:0] mem_read_data_q, mem_read_data_d, host_rdata_q, host_rdata_d;
    logic        host_rej_q, host_rej_d, busy_q, busy_d, result_valid_q, result_valid_d;
    logic        oob_err_q, oob_err_d, timeout_err_q, timeout_err_d, eng_done_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  tmr_q, tmr_d;
    logic        eng_ok, host_ok, host_acc, host_svc, in_win, done_rise;

    assign eng_ok    = 32'(mem_addr) < DEPTH;
    assign host_ok   = 32'(host_addr) < DEPTH;
    assign host_acc  = host_we || host_re;
    assign host_svc  = !busy_q;
    assign in_win    = mem_addr >= OUT_BASE && mem_addr <= OUT_BASE + 16'd7;
    assign done_rise = eng_done && !eng_done_q;

    always_ff @(posedge clk) begin
        if (host_we && host_svc && host_ok) ram_q[host_addr[AW-1:0]] <= host_wdata;
        if (mem_we && eng_ok) ram_q[mem_addr[AW-1:0]] <= mem_write_data;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (host_start) state_d = LAUNCH;
            LAUNCH:  if (!eng_done) state_d = RUN;
                     else if (tmr_q == TMR_LAST) state_d = IDLE;
            RUN:     if (done_rise) state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        eng_start       = state_q == LAUNCH;
        cnt_d           = cnt_q;
        tmr_d           = tmr_q;
        busy_d          = busy_q;
        result_valid_d  = result_valid_q;
        timeout_err_d   = timeout_err_q;
        case (state_q)
            IDLE: if (host_start) begin
                cnt_d          = 4'd0;
                tmr_d          = 8'd0;
                busy_d         = 1'b1;
                result_valid_d = 1'b0;
                timeout_err_d  = 1'b0;
            end
            LAUNCH: begin
                tmr_d = tmr_q + 8'd1;
                if (eng_done && tmr_q == TMR_LAST) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                end
            end
            RUN: if (mem_we && in_win && cnt_q != 4'd8) cnt_d = cnt_q + 4'd1;
            CHECK: begin
                result_valid_d = cnt_q == 4'd8;
                busy_d         = 1'b0;
            end
            default: ;
        endcase
        mem_read_data_d = eng_ok ? ram_q[mem_addr[AW-1:0]] : 32'd0;
        host_rdata_d    = (host_re && host_svc) ? (host_ok ? ram_q[host_addr[AW-1:0]] : 32'd0) : host_rdata_q;
        host_rej_d      = busy_q && (host_acc || host_start);
        // Engine reads every cycle, so its address alone counts as an access.
        oob_err_d       = oob_err_q || !eng_ok || (host_acc && host_svc && !host_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_data_q <= 32'd0;
            host_rdata_q    <= 32'd0;
            host_rej_q      <= 1'b0;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            oob_err_q       <= 1'b0;
            timeout_err_q   <= 1'b0;
            eng_done_q      <= 1'b0;
            cnt_q           <= 4'd0;
            tmr_q           <= 8'd0;
        end else begin
            mem_read_data_q <= mem_read_data_d;
            host_rdata_q    <= host_rdata_d;
            host_rej_q      <= host_rej_d;
            busy_q          <= busy_d;
            result_valid_q  <= result_valid_d;
            oob_err_q       <= oob_err_d;
            timeout_err_q   <= timeout_err_d;
            eng_done_q      <= eng_done;
            cnt_q           <= cnt_d;
            tmr_q           <= tmr_d;
        end
    end

    assign mem_read_data = mem_read_data_q;
    assign host_rdata    = host_rdata_q;
    assign host_rej      = host_rej_q;
    assign busy          = busy_q;
    assign result_valid  = result_valid_q;
    assign oob_err       = oob_err_q;
    assign timeout_err   = timeout_err_q;
    assign eng_wr_count  = cnt_q;
    assign message_addr  = MSG_BASE;
    assign output_addr   = OUT_BASE;
endmodule
